// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver: FSM encoding and default bit timing.
package serial_pkg;

  localparam int unsigned BIT_CLKS_DEFAULT = 278;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } serial_state_e;

endpackage

// File: rtl/serial_tx_fifo.sv
// Byte FIFO with registered read data and occupancy; pointers wrap modulo DEPTH (power of two).
module serial_tx_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk64,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       wr_data,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic [LVL_W-1:0] level
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk64) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk64) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/serial_tx.sv
// Buffered 8N1/8N2 serial transmitter: bytes queue in a FIFO and are framed LSB first on tx.
module serial_tx
  import serial_pkg::*;
#(
  parameter  int unsigned BIT_CLKS   = BIT_CLKS_DEFAULT,
  parameter  int unsigned STOP_BITS  = 1,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk64,
  input  logic             reset,
  input  logic [7:0]       tx_byte,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int unsigned      CNT_W     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  serial_state_e    state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             push, pop, bit_end;
  logic [7:0]       fifo_data;
  logic [LVL_W-1:0] level_next;

  assign push       = tx_valid && tx_ready_q;
  assign bit_end    = (clk_cnt_q == CNT_LAST);
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk64   (clk64),
    .reset   (reset),
    .push    (push),
    .wr_data (tx_byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .level   (fifo_level)
  );

  // Next state; the popped byte lands in fifo_data a cycle later, so it is loaded at the end of START.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    if (state_q != ST_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (fifo_level != '0) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          shift_d   = fifo_data;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (fifo_level != '0) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs; tx and busy trail the state register by one cycle together.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    tx_ready_d = (level_next != LVL_FULL);
    busy_d     = (state_q != ST_IDLE) || (fifo_level != '0);
  end

  always_ff @(posedge clk64) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter BIT_CLKS, default 278, SHALL set clocks per bit; 278 at 64 MHz gives about 230400 bps.
REQ-002 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the number of queued bytes; power of two, 2..16.
REQ-004 clk64  input  1  SHALL be the single 64 MHz clock; all logic on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-low (0 = reset).
REQ-006 tx_byte  input  8  SHALL carry the byte to send.
REQ-007 tx_valid  input  1  SHALL mark tx_byte as offered.
REQ-008 tx_ready  output  1  SHALL be high when the FIFO can accept a byte.
REQ-009 tx  output  1  SHALL be the registered serial line, idle high.
REQ-010 busy  output  1  SHALL be high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  SHALL give the current FIFO occupancy.

Function
REQ-012 A byte SHALL be accepted on any edge where tx_valid and tx_ready are both high; otherwise tx_byte SHALL be ignored.
REQ-013 tx_ready SHALL equal !full, decoded from registered occupancy; a pop in the same cycle SHALL NOT raise tx_ready in that cycle.
REQ-014 A push and a pop on the same edge SHALL leave fifo_level unchanged; a byte SHALL never bypass the FIFO.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; when the FIFO is non-empty, the FSM SHALL pop the head byte into an 8-bit shift register and go to START.
REQ-017 START: tx=0 for BIT_CLKS cycles, then go to DATA.
REQ-018 DATA: tx SHALL carry shift-register bit 0, LSB first, each bit for BIT_CLKS cycles; after 8 bits go to STOP.
REQ-019 STOP: tx=1 for STOP_BITS*BIT_CLKS cycles.
REQ-020 At the end of STOP, the FSM SHALL go to START with a pop if the FIFO is non-empty, else to IDLE.
REQ-021 Back-to-back frames SHALL have zero idle cycles between the stop bit and the next start bit.
REQ-022 Bit timing SHALL use one counter running 0..BIT_CLKS-1; it SHALL run only outside IDLE and wrap to 0 on every bit boundary.
REQ-023 A 4-bit bit counter SHALL count the data bits 0..7.
REQ-024 Latency: if a byte is accepted at edge k while IDLE with an empty FIFO, tx SHALL be 0 from edge k+2.
REQ-025 Frame length SHALL be (9+STOP_BITS)*BIT_CLKS cycles exactly.
REQ-026 tx SHALL come straight from a flop with no combinational path from any input.
REQ-027 busy SHALL be (state!=IDLE) || (fifo_level!=0).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full SHALL be level==FIFO_DEPTH and empty SHALL be level==0.

Reset
REQ-029 While reset=0 at an edge, the block SHALL load: tx=1, state=IDLE, both counters=0, FIFO empty, fifo_level=0, tx_ready=0, busy=0.
REQ-030 tx_ready SHALL go high on the first edge after reset is released.
REQ-031 Reset asserted mid-frame SHALL drive tx=1 from the next edge and discard all queued bytes; no partial frame SHALL resume.

Structure
REQ-032 The FIFO SHALL be a separate sub-module, serial_tx_fifo (8-bit wide, FIFO_DEPTH deep, synchronous read), with a level output.
REQ-033 The FSM state encoding and default BIT_CLKS SHALL live in the shared package serial_pkg, also used by the receiver.

Verification
REQ-034 Send 0xA5 from idle -> tx line bits 0,1,0,1,0,0,1,0,1,1, each held 278 cycles; tx low at k+2.
REQ-035 Push 0x00, 0xFF, 0x55 on consecutive edges -> three frames with no idle gap, 30*278 cycles total; busy falls after the final stop bit.
REQ-036 Push 5 bytes with the line busy -> tx_ready low at level 4; the fifth byte held until a pop, then accepted; all 5 bytes appear in order.
REQ-037 Assert reset at cycle 1000 of a 0x3C frame -> tx=1 next edge; fifo_level=0; no further frames.
REQ-038 STOP_BITS=2, loop tx back into the serial receiver, send bytes 0x00..0xFF -> every byte received correctly; frame period 11*278 cycles.
